// File: rtl/psw_flag_unit.sv
// PSW flag register (N,Z,V,C as JK flops) with direct load, a LIFO save/restore
// stack for interrupt entry/return, and a registered branch-condition evaluator.
module psw_flag_unit #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       J_N,
  input  logic       K_N,
  input  logic       J_Z,
  input  logic       K_Z,
  input  logic       J_V,
  input  logic       K_V,
  input  logic       J_C,
  input  logic       K_C,
  input  logic       psw_we,
  input  logic [3:0] psw_wdata,
  input  logic       save,
  input  logic       restore,
  input  logic       cond_eval,
  input  logic [3:0] cond_code,
  output logic       N,
  output logic       Z,
  output logic       V,
  output logic       C,
  output logic [3:0] psw,
  output logic       branch_valid,
  output logic       branch_taken,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    psw_q, psw_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    stack_q [DEPTH];
  logic          bv_q, bt_q, bt_d, err_q, err_d, full_q, empty_q;
  logic [3:0]    j_s, k_s, top_s;
  logic          is_full_s, is_empty_s, push_ok_s, pop_ok_s;

  // Condition codes evaluate against {N,Z,V,C} as it stood before this edge.
  function automatic logic cond_fn(input logic [3:0] code, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (code)
      4'd0:    cond_fn = 1'b1;
      4'd1:    cond_fn = z;
      4'd2:    cond_fn = ~z;
      4'd3:    cond_fn = n;
      4'd4:    cond_fn = ~n;
      4'd5:    cond_fn = v;
      4'd6:    cond_fn = ~v;
      4'd7:    cond_fn = c;
      4'd8:    cond_fn = ~c;
      4'd9:    cond_fn = n ^ v;
      4'd10:   cond_fn = ~(n ^ v);
      4'd11:   cond_fn = z | (n ^ v);
      4'd12:   cond_fn = ~(z | (n ^ v));
      4'd13:   cond_fn = ~(c | z);
      4'd14:   cond_fn = c | z;
      default: cond_fn = 1'b0;
    endcase
  endfunction

  // Next-state: stack arbitration, PSW source priority, branch evaluation.
  always_comb begin
    j_s = {J_N, J_Z, J_V, J_C};
    k_s = {K_N, K_Z, K_V, K_C};
    top_s = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) begin
        top_s = stack_q[i];
      end else begin
        top_s = top_s;
      end
    end
    is_full_s  = (count_q == CW'(DEPTH));
    is_empty_s = (count_q == {CW{1'b0}});
    // Simultaneous save+restore is treated as illegal and neither is performed.
    push_ok_s = save & ~restore & ~is_full_s;
    pop_ok_s  = restore & ~save & ~is_empty_s;
    err_d     = (save & restore) | (save & ~restore & is_full_s) |
                (restore & ~save & is_empty_s);
    if (push_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    if (pop_ok_s) begin
      psw_d = top_s;
    end else if (psw_we) begin
      psw_d = psw_wdata;
    end else begin
      psw_d = (j_s & ~psw_q) | (~k_s & psw_q);
    end
    if (cond_eval) begin
      bt_d = cond_fn(cond_code, psw_q);
    end else begin
      bt_d = bt_q;
    end
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psw_q   <= 4'b0000;
      count_q <= {CW{1'b0}};
      bv_q    <= 1'b0;
      bt_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      psw_q   <= psw_d;
      count_q <= count_d;
      bv_q    <= cond_eval;
      bt_q    <= bt_d;
      err_q   <= err_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == {CW{1'b0}});
    end
  end

  // Stack storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_ok_s && (count_q == CW'(i))) begin
        stack_q[i] <= psw_q;
      end
    end
  end

  assign psw          = psw_q;
  assign N            = psw_q[3];
  assign Z            = psw_q[2];
  assign V            = psw_q[1];
  assign C            = psw_q[0];
  assign branch_valid = bv_q;
  assign branch_taken = bt_q;
  assign stack_full   = full_q;
  assign stack_empty  = empty_q;
  assign stack_err    = err_q;

endmodule
